// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared screen/tile dimensions and tile_pixels FSM state type
package tile_pkg;

  localparam int DEFAULT_SCREEN_WIDTH  = 1280;
  localparam int DEFAULT_SCREEN_HEIGHT = 720;
  localparam int DEFAULT_TILE_WIDTH    = 16;
  localparam int DEFAULT_TILE_HEIGHT   = 24;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    EMIT,
    DONE
  } t_tile_pixels_state;

endpackage

// File: rtl/tile_rowdiv.sv
// rtl/tile_rowdiv.sv - iterative subtract divider, one subtraction per cycle
// done is combinational in the cycle the remainder first drops below the divisor.
module tile_rowdiv #(
  parameter int DIVISOR       = 80,
  parameter int DIVIDEND_BITS = 12,
  parameter int QUOT_BITS     = 5,
  parameter int REM_BITS      = 7
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_start,
  input  logic [DIVIDEND_BITS-1:0] in_dividend,
  output logic                     out_done,
  output logic [QUOT_BITS-1:0]     out_quot,
  output logic [REM_BITS-1:0]      out_rem
);

  localparam logic [DIVIDEND_BITS-1:0] DIV_C = DIVIDEND_BITS'(DIVISOR);

  logic [DIVIDEND_BITS-1:0] rem_q;
  logic [QUOT_BITS-1:0]     quot_q;
  logic                     busy_q;

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      busy_q <= 1'b0;
    end else if (in_start) begin
      rem_q  <= in_dividend;
      quot_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (rem_q >= DIV_C) begin
        rem_q  <= rem_q - DIV_C;
        quot_q <= quot_q + QUOT_BITS'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign out_done = busy_q && (rem_q < DIV_C);
  assign out_quot = quot_q;
  assign out_rem  = REM_BITS'(rem_q);

endmodule

// File: rtl/tile_pixels.sv
// rtl/tile_pixels.sv - enumerate every screen pixel of one tile in row-major order
// Define TILE_PIXELS_ADDR_EN to produce the linear framebuffer address on out_addr.
module tile_pixels
  import tile_pkg::*;
#(
  parameter int SCREEN_WIDTH       = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT      = DEFAULT_SCREEN_HEIGHT,
  parameter int TILE_WIDTH         = DEFAULT_TILE_WIDTH,
  parameter int TILE_HEIGHT        = DEFAULT_TILE_HEIGHT,
  parameter int TILES_X            = SCREEN_WIDTH / TILE_WIDTH,
  parameter int TILES_Y            = SCREEN_HEIGHT / TILE_HEIGHT,
  parameter int SCREEN_WIDTH_BITS  = $clog2(SCREEN_WIDTH),
  parameter int SCREEN_HEIGHT_BITS = $clog2(SCREEN_HEIGHT),
  parameter int TILE_WIDTH_BITS    = $clog2(TILE_WIDTH),
  parameter int TILE_HEIGHT_BITS   = $clog2(TILE_HEIGHT),
  parameter int TILE_X_BITS        = $clog2(TILES_X),
  parameter int TILE_Y_BITS        = $clog2(TILES_Y),
  parameter int TILE_NUM_BITS      = $clog2(TILES_X * TILES_Y),
  parameter int ADDR_BITS          = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_start,
  input  logic [TILE_NUM_BITS-1:0]      in_tile_num,
  input  logic                          in_ack,
  output logic                          out_busy,
  output logic                          out_valid,
  output logic [SCREEN_WIDTH_BITS-1:0]  out_pix_x,
  output logic [SCREEN_HEIGHT_BITS-1:0] out_pix_y,
  output logic [TILE_WIDTH_BITS-1:0]    out_tile_pix_x,
  output logic [TILE_HEIGHT_BITS-1:0]   out_tile_pix_y,
  output logic [ADDR_BITS-1:0]          out_addr,
  output logic                          out_done,
  output logic                          out_err
);

  localparam int TILE_COUNT = TILES_X * TILES_Y;
  localparam logic [TILE_WIDTH_BITS-1:0]  TPX_LAST = TILE_WIDTH_BITS'(TILE_WIDTH - 1);
  localparam logic [TILE_HEIGHT_BITS-1:0] TPY_LAST = TILE_HEIGHT_BITS'(TILE_HEIGHT - 1);

  t_tile_pixels_state state_q, state_d;

  logic [TILE_X_BITS-1:0]      tile_x_q;
  logic [TILE_Y_BITS-1:0]      tile_y_q;
  logic [TILE_WIDTH_BITS-1:0]  tile_pix_x_q;
  logic [TILE_HEIGHT_BITS-1:0] tile_pix_y_q;
  logic                        err_q;

  logic                   in_range;
  logic                   div_start;
  logic                   div_done;
  logic [TILE_Y_BITS-1:0] div_quot;
  logic [TILE_X_BITS-1:0] div_rem;
  logic                   load_tile;
  logic                   advance;
  logic                   last_pix;

  // Compare at 32 bits so a power-of-two tile count cannot alias to zero.
  assign in_range = 32'(in_tile_num) < 32'(TILE_COUNT);
  assign last_pix = (tile_pix_x_q == TPX_LAST) && (tile_pix_y_q == TPY_LAST);

  tile_rowdiv #(
    .DIVISOR       (TILES_X),
    .DIVIDEND_BITS (TILE_NUM_BITS),
    .QUOT_BITS     (TILE_Y_BITS),
    .REM_BITS      (TILE_X_BITS)
  ) u_rowdiv (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_start    (div_start),
    .in_dividend (in_tile_num),
    .out_done    (div_done),
    .out_quot    (div_quot),
    .out_rem     (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    load_tile = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start && in_range) begin
          div_start = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        if (div_done) begin
          load_tile = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (in_ack) begin
          advance = 1'b1;
          if (last_pix) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q      <= IDLE;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      tile_pix_x_q <= '0;
      tile_pix_y_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && in_start && !in_range;
      if (load_tile) begin
        tile_x_q     <= div_rem;
        tile_y_q     <= div_quot;
        tile_pix_x_q <= '0;
        tile_pix_y_q <= '0;
      end else if (advance) begin
        if (tile_pix_x_q == TPX_LAST) begin
          tile_pix_x_q <= '0;
          tile_pix_y_q <= last_pix ? '0 : tile_pix_y_q + TILE_HEIGHT_BITS'(1);
        end else begin
          tile_pix_x_q <= tile_pix_x_q + TILE_WIDTH_BITS'(1);
        end
      end
    end
  end

  assign out_busy       = (state_q != IDLE);
  assign out_valid      = (state_q == EMIT);
  assign out_done       = (state_q == DONE);
  assign out_err        = err_q;
  assign out_tile_pix_x = tile_pix_x_q;
  assign out_tile_pix_y = tile_pix_y_q;
  assign out_pix_x = SCREEN_WIDTH_BITS'(32'(tile_x_q) * TILE_WIDTH + 32'(tile_pix_x_q));
  assign out_pix_y = SCREEN_HEIGHT_BITS'(32'(tile_y_q) * TILE_HEIGHT + 32'(tile_pix_y_q));

`ifdef TILE_PIXELS_ADDR_EN
  localparam int ROW_STRIDE = TILE_HEIGHT * SCREEN_WIDTH;
  localparam logic [ADDR_BITS-1:0] WRAP_STEP = ADDR_BITS'(SCREEN_WIDTH - TILE_WIDTH + 1);

  logic [ADDR_BITS-1:0] addr_q;

  // Base address multiplies once per tile; after that the address only steps.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      addr_q <= '0;
    end else if (load_tile) begin
      addr_q <= ADDR_BITS'(32'(div_quot) * ROW_STRIDE + 32'(div_rem) * TILE_WIDTH);
    end else if (advance) begin
      addr_q <= addr_q + ((tile_pix_x_q == TPX_LAST) ? WRAP_STEP : ADDR_BITS'(1));
    end
  end

  assign out_addr = addr_q;
`else
  assign out_addr = '0;
`endif

endmodule
